// File: rtl/im_loader_pkg.sv
// Shared processor package: loader state encoding and word geometry.
package im_loader_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/im_word_assembler.sv
// Packs consecutive bytes little-endian into a 32-bit word; byte index wraps after the last byte.
module im_word_assembler
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_data,
    output logic [BIDX_W-1:0] byte_idx,
    output logic [31:0]       word,
    output logic              last_byte
);
    logic [BIDX_W-1:0] idx_q, idx_d;
    logic [31:0]       word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (load) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_data;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign byte_idx  = idx_q;
    assign word      = word_q;
    assign last_byte = (idx_q == BIDX_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/im_loader.sv
// Streams bytes into instruction memory, one single-cycle write strobe per assembled word.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int NUM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_write,
    output logic [31:0] im_addr,
    output logic [31:0] im_data,
    output logic        busy,
    output logic        done,
    output logic [4:0]  word_count
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [4:0]  wc_q, wc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic              asm_clear;
    logic              byte_fire;
    logic [BIDX_W-1:0] asm_idx;
    logic [31:0]       asm_word;
    logic              asm_last;

    // Abort and reset gate the handshake and strobe within the same cycle.
    assign byte_ready = (state_q == ST_COLLECT) && !abort && !reset;
    assign byte_fire  = byte_valid && byte_ready;
    assign im_write   = (state_q == ST_WRITE) && !abort && !reset;

    im_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (byte_fire),
        .byte_data (byte_data),
        .byte_idx  (asm_idx),
        .word      (asm_word),
        .last_byte (asm_last)
    );

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        wc_d      = wc_q;
        addr_d    = addr_q;
        data_d    = data_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_COLLECT;
                    widx_d    = '0;
                    wc_d      = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    asm_clear = 1'b1;
                end else if (byte_fire && asm_last) begin
                    // Capture address/data now so they are stable for the whole WRITE cycle.
                    state_d = ST_WRITE;
                    addr_d  = {26'd0, widx_q, 2'b00};
                    data_d  = {byte_data, asm_word[23:0]};
                end
            end
            ST_WRITE: begin
                asm_clear = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wc_d = wc_q + 5'd1;
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        widx_d  = widx_q + 4'd1;
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            wc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign im_addr    = addr_q;
    assign im_data    = data_q;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign word_count = wc_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, asm_idx};
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: full loads, gaps, abort, reset mid-write, restart.
module tb_im_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        im_write;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int run = 0;
    int max_run = 0;

    im_loader #(.NUM_WORDS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .im_write(im_write), .im_addr(im_addr), .im_data(im_data),
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory model: one write per falling edge seen with the strobe high.
    always @(negedge clk) begin
        if (im_write === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_data);
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] stim_byte(input int i);
        case (i)
            0: return 8'h05;
            1: return 8'hE0;
            2: return 8'hFE;
            3: return 8'h00;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        return {stim_byte(4*w+3), stim_byte(4*w+2), stim_byte(4*w+1), stim_byte(4*w)};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        wr_addr.delete(); wr_data.delete(); max_run = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        n = 0; ok = 1'b0;
        byte_valid = 1'b1; byte_data = b;
        while (!ok && n < 20) begin
            @(negedge clk); ok = (byte_ready === 1'b1);
            tick(); n++;
        end
        byte_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte_timeout byte=%02h got no byte_ready within 20 cycles", b);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0h exp=0", done); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%0h exp=0", byte_ready); end
        n_cmp++; if (im_write !== 1'b0) begin n_bad++; $display("FAIL reset_write got=%0h exp=0", im_write); end
        n_cmp++; if ({im_addr, im_data} !== 64'd0) begin n_bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", im_addr, im_data); end
        n_cmp++; if (word_count !== 5'd0) begin n_bad++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
    endtask

    task automatic check_full_load(input string tag);
        n_cmp++; if (wr_addr.size() !== 16) begin n_bad++; $display("FAIL %s_nwrites got=%0d exp=16", tag, wr_addr.size()); end
        for (int w = 0; w < 16 && w < wr_addr.size(); w++) begin
            n_cmp++; if (wr_addr[w] !== 32'(w*4)) begin n_bad++; $display("FAIL %s_addr%0d got=%h exp=%h", tag, w, wr_addr[w], 32'(w*4)); end
            n_cmp++; if (wr_data[w] !== exp_word(w)) begin n_bad++; $display("FAIL %s_data%0d got=%h exp=%h", tag, w, wr_data[w], exp_word(w)); end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done got=%0h exp=1", tag, done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy got=%0h exp=0", tag, busy); end
        n_cmp++; if (word_count !== 5'd16) begin n_bad++; $display("FAIL %s_wc got=%0d exp=16", tag, word_count); end
        n_cmp++; if (im_addr !== 32'h3C) begin n_bad++; $display("FAIL %s_final_addr got=%h exp=3c", tag, im_addr); end
        n_cmp++; if (max_run !== 1) begin n_bad++; $display("FAIL %s_strobe_width got=%0d exp=1", tag, max_run); end
    endtask

    task automatic test_full_load();
        do_reset();
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got=%0h exp=1", busy); end
        for (int i = 0; i < 64; i++) send_byte(stim_byte(i));
        tick(); tick();
        n_cmp++; if (wr_data.size() == 0 || wr_data[0] !== 32'h00FEE005) begin n_bad++; $display("FAIL full_first_word got=%h exp=00fee005", wr_data.size() ? wr_data[0] : 32'hx); end
        check_full_load("full");
    endtask

    task automatic test_restart();
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_abort_ignored got=%0h exp=1", done); end
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done got=%0h exp=0", done); end
        n_cmp++; if (word_count !== 5'd0) begin n_bad++; $display("FAIL restart_wc got=%0d exp=0", word_count); end
        for (int i = 0; i < 4; i++) send_byte(stim_byte(i));
        tick();
        n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL restart_nwrites got=%0d exp=1", wr_addr.size()); end
        else begin
            n_cmp++; if (wr_addr[0] !== 32'h0) begin n_bad++; $display("FAIL restart_addr got=%h exp=0", wr_addr[0]); end
            n_cmp++; if (wr_data[0] !== 32'h00FEE005) begin n_bad++; $display("FAIL restart_data got=%h exp=00fee005", wr_data[0]); end
        end
        n_cmp++; if (word_count !== 5'd1) begin n_bad++; $display("FAIL restart_wc1 got=%0d exp=1", word_count); end
    endtask

    task automatic test_gaps();
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send_byte(stim_byte(i));
            tick();
        end
        tick();
        check_full_load("gaps");
    endtask

    task automatic test_abort();
        do_reset();
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(stim_byte(i));
        abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready got=%0h exp=0", byte_ready); end
        tick(); abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%0h exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%0h exp=0", done); end
        n_cmp++; if (word_count !== 5'd2) begin n_bad++; $display("FAIL abort_wc got=%0d exp=2", word_count); end
        byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL abort_idle_ready got=%0h exp=0", byte_ready); end
        byte_valid = 1'b0;
        n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("FAIL abort_nwrites got=%0d exp=2", wr_addr.size()); end
    endtask

    task automatic test_abort_coincident();
        do_reset();
        pulse_start();
        send_byte(8'h99); send_byte(8'h88);
        byte_valid = 1'b1; byte_data = 8'hAA; abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL coinc_ready got=%0h exp=0", byte_ready); end
        tick(); abort = 1'b0; byte_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL coinc_busy got=%0h exp=0", busy); end
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick();
        n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL coinc_nwrites got=%0d exp=1", wr_addr.size()); end
        else begin
            n_cmp++; if (wr_addr[0] !== 32'h0) begin n_bad++; $display("FAIL coinc_addr got=%h exp=0", wr_addr[0]); end
            n_cmp++; if (wr_data[0] !== 32'h44332211) begin n_bad++; $display("FAIL coinc_data got=%h exp=44332211", wr_data[0]); end
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(stim_byte(i));
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL collect_start_busy got=%0h exp=1", busy); end
        for (int i = 10; i < 24; i++) send_byte(stim_byte(i));
        n_cmp++; if (im_write !== 1'b1) begin n_bad++; $display("FAIL w5_write got=%0h exp=1", im_write); end
        n_cmp++; if (im_addr !== 32'h14) begin n_bad++; $display("FAIL w5_addr got=%h exp=14", im_addr); end
        n_cmp++; if (word_count !== 5'd5) begin n_bad++; $display("FAIL w5_wc got=%0d exp=5", word_count); end
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        n_cmp++; if ({im_write, busy, done, byte_ready} !== 4'b0) begin n_bad++; $display("FAIL rst_w_flags got=%b exp=0000", {im_write, busy, done, byte_ready}); end
        n_cmp++; if ({im_addr, im_data} !== 64'd0) begin n_bad++; $display("FAIL rst_w_addr_data got=%h/%h exp=0/0", im_addr, im_data); end
        n_cmp++; if (word_count !== 5'd0) begin n_bad++; $display("FAIL rst_w_wc got=%0d exp=0", word_count); end
        n_cmp++; if (wr_addr.size() !== 5) begin n_bad++; $display("FAIL rst_w_nwrites got=%0d exp=5", wr_addr.size()); end
        else begin
            n_cmp++; if (wr_data[2] !== exp_word(2)) begin n_bad++; $display("FAIL rst_w_word2 got=%h exp=%h", wr_data[2], exp_word(2)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_restart();
        test_gaps();
        test_abort();
        test_abort_coincident();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
